// File: rtl/barrel_shifter_pipe.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR/RRX, immediate and register forms)
// with shifter carry-out and whole-pipe valid/ready back-pressure.
module barrel_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Shift_Data,
    input  logic [NUM_W-1:0] Shift_Num,
    input  logic [2:0]       SHIFT_OP,
    input  logic             Carry_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Shift_out,
    output logic             Shift_carry_out
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [NUM_W-1:0] W_NUM   = NUM_W'(WIDTH);
    localparam logic [AW:0]      W_AMT   = (AW+1)'(WIDTH);
    localparam logic [AW:0]      WM1_AMT = (AW+1)'(WIDTH - 1);
    localparam logic [AW-1:0]    TOP_IDX = AW'(WIDTH - 1);

    typedef enum logic [2:0] {K_LSL, K_LSR, K_ASR, K_ROR, K_RRX} kind_t;
    typedef enum logic [1:0] {CM_C, CM_ZERO, CM_BIT} cmode_t;

    // Handshake: a transfer happens on an edge where valid && ready. The whole pipe
    // advances together when the output slot is empty or being drained; otherwise
    // every stage holds and in_ready is low.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    kind_t         kind_d;
    cmode_t        cmode_d;
    logic [AW:0]   amt_d;
    logic [AW-1:0] cidx_d;
    logic [AW:0]   lsl_idx;
    logic          imm_form;

    assign imm_form = ~SHIFT_OP[0];
    assign lsl_idx  = W_AMT - Shift_Num[AW:0];

    // Every case is reduced to one shift kind, a shift amount of 0..W and a carry source.
    // "Pass" is LSL by 0 and "result zero" is LSR by W.
    always_comb begin
        kind_d  = K_LSL;
        cmode_d = CM_C;
        amt_d   = '0;
        cidx_d  = '0;
        if (Shift_Num == '0 && (!imm_form || SHIFT_OP[2:1] == 2'b00)) begin
            kind_d  = K_LSL;
            cmode_d = CM_C;
        end else begin
            case (SHIFT_OP[2:1])
                2'b00: begin
                    if (Shift_Num <= W_NUM) begin
                        kind_d  = K_LSL;
                        amt_d   = Shift_Num[AW:0];
                        cmode_d = CM_BIT;
                        cidx_d  = lsl_idx[AW-1:0];
                    end else begin
                        kind_d  = K_LSR;
                        amt_d   = W_AMT;
                        cmode_d = CM_ZERO;
                    end
                end
                2'b01: begin
                    kind_d = K_LSR;
                    if (Shift_Num == '0) begin
                        amt_d   = W_AMT;
                        cmode_d = CM_BIT;
                        cidx_d  = TOP_IDX;
                    end else if (Shift_Num <= W_NUM) begin
                        amt_d   = Shift_Num[AW:0];
                        cmode_d = CM_BIT;
                        cidx_d  = Shift_Num[AW-1:0] - AW'(1);
                    end else begin
                        amt_d   = W_AMT;
                        cmode_d = CM_ZERO;
                    end
                end
                2'b10: begin
                    kind_d  = K_ASR;
                    cmode_d = CM_BIT;
                    if (Shift_Num == '0 || Shift_Num >= W_NUM) begin
                        amt_d  = WM1_AMT;
                        cidx_d = TOP_IDX;
                    end else begin
                        amt_d  = Shift_Num[AW:0];
                        cidx_d = Shift_Num[AW-1:0] - AW'(1);
                    end
                end
                default: begin
                    cmode_d = CM_BIT;
                    if (Shift_Num == '0) begin
                        kind_d = K_RRX;
                        cidx_d = '0;
                    end else if (Shift_Num[AW-1:0] == '0) begin
                        kind_d = K_LSL;
                        cidx_d = TOP_IDX;
                    end else begin
                        kind_d = K_ROR;
                        amt_d  = {1'b0, Shift_Num[AW-1:0]};
                        cidx_d = Shift_Num[AW-1:0] - AW'(1);
                    end
                end
            endcase
        end
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_c;
    kind_t            s1_kind;
    cmode_t           s1_cmode;
    logic [AW:0]      s1_amt;
    logic [AW-1:0]    s1_cidx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_c     <= 1'b0;
            s1_kind  <= K_LSL;
            s1_cmode <= CM_C;
            s1_amt   <= '0;
            s1_cidx  <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data  <= Shift_Data;
                s1_c     <= Carry_flag;
                s1_kind  <= kind_d;
                s1_cmode <= cmode_d;
                s1_amt   <= amt_d;
                s1_cidx  <= cidx_d;
            end
        end
    end

    logic [WIDTH-1:0] res_d;
    logic             carry_d;

    always_comb begin
        res_d   = s1_data;
        carry_d = 1'b0;
        case (s1_kind)
            K_LSL:   res_d = s1_data << s1_amt;
            K_LSR:   res_d = s1_data >> s1_amt;
            K_ASR:   res_d = $unsigned($signed(s1_data) >>> s1_amt);
            K_ROR:   res_d = (s1_data >> s1_amt) | (s1_data << (W_AMT - s1_amt));
            K_RRX:   res_d = {s1_c, s1_data[WIDTH-1:1]};
            default: res_d = s1_data;
        endcase
        case (s1_cmode)
            CM_C:    carry_d = s1_c;
            CM_BIT:  carry_d = s1_data[s1_cidx];
            default: carry_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            Shift_out       <= '0;
            Shift_carry_out <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Shift_out       <= res_d;
                Shift_carry_out <= carry_d;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: directed vector table at WIDTH=32, back-pressure,
// bubble and mid-flight reset sequences, plus WIDTH=8/64 instances against a bit-level model.
module tb_barrel_shifter_pipe;

    localparam int W  = 32;
    localparam int NW = 8;
    localparam int NV = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT (WIDTH = 32) ----------------
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  Shift_Data, Shift_out;
    logic [NW-1:0] Shift_Num;
    logic [2:0]    SHIFT_OP;
    logic          Carry_flag, Shift_carry_out;

    barrel_shifter_pipe #(.WIDTH(W), .NUM_W(NW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Shift_Data(Shift_Data), .Shift_Num(Shift_Num), .SHIFT_OP(SHIFT_OP),
        .Carry_flag(Carry_flag), .out_valid(out_valid), .out_ready(out_ready),
        .Shift_out(Shift_out), .Shift_carry_out(Shift_carry_out)
    );

    // ---------------- sweep DUTs (WIDTH = 8 and 64) ----------------
    logic          s_in_valid, s_c;
    logic [2:0]    s_op;
    logic [NW-1:0] s8_num, s64_num;
    logic [7:0]    s8_data, s8_out;
    logic [63:0]   s64_data, s64_out;
    logic          s8_in_ready, s8_out_valid, s8_carry;
    logic          s64_in_ready, s64_out_valid, s64_carry;

    barrel_shifter_pipe #(.WIDTH(8), .NUM_W(NW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s8_in_ready),
        .Shift_Data(s8_data), .Shift_Num(s8_num), .SHIFT_OP(s_op),
        .Carry_flag(s_c), .out_valid(s8_out_valid), .out_ready(1'b1),
        .Shift_out(s8_out), .Shift_carry_out(s8_carry)
    );

    barrel_shifter_pipe #(.WIDTH(64), .NUM_W(NW)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s64_in_ready),
        .Shift_Data(s64_data), .Shift_Num(s64_num), .SHIFT_OP(s_op),
        .Carry_flag(s_c), .out_valid(s64_out_valid), .out_ready(1'b1),
        .Shift_out(s64_out), .Shift_carry_out(s64_carry)
    );

    // ---------------- scoreboard ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        string         name;
        logic [2:0]    op;
        logic [NW-1:0] num;
        logic [W-1:0]  data;
        logic          c;
        logic [W-1:0]  exp_out;
        logic          exp_c;
    } vec_t;

    vec_t vecs[NV];

    task automatic set_vec(input int i, input string nm, input logic [2:0] op, input logic [NW-1:0] num,
                           input logic [W-1:0] d, input logic c, input logic [W-1:0] eo, input logic ec);
        vecs[i].name = nm; vecs[i].op = op; vecs[i].num = num; vecs[i].data = d;
        vecs[i].c = c; vecs[i].exp_out = eo; vecs[i].exp_c = ec;
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [2:0] op, input logic [NW-1:0] num, input logic [W-1:0] d, input logic c);
        in_valid = 1'b1; SHIFT_OP = op; Shift_Num = num; Shift_Data = d; Carry_flag = c;
    endtask

    task automatic drive_vec(input int i);
        drive(vecs[i].op, vecs[i].num, vecs[i].data, vecs[i].c);
    endtask

    task automatic check_result(input string tag, input int i);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".out"}, Shift_out, vecs[i].exp_out);
        check({tag, ".carry"}, Shift_carry_out, vecs[i].exp_c);
    endtask

    // Independent bit-level reference, written straight from the operation table.
    function automatic logic [64:0] model(input int w, input logic [63:0] d_in, input int n_in,
                                          input logic [2:0] op, input logic c);
        logic [63:0] d, res, mask;
        logic        cy;
        int          n, r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        d    = d_in & mask;
        n    = n_in;
        res  = d;
        cy   = c;
        if (!(op[0] && n == 0)) begin
            case (op[2:1])
                2'b00: begin
                    if (n == 0) begin res = d; cy = c; end
                    else if (n <= w) begin res = (d << n) & mask; cy = d[w-n]; end
                    else begin res = '0; cy = 1'b0; end
                end
                2'b01: begin
                    if (n == 0) n = w;
                    if (n <= w) begin res = d >> n; cy = d[n-1]; end
                    else begin res = '0; cy = 1'b0; end
                end
                2'b10: begin
                    if (n == 0 || n >= w) begin res = d[w-1] ? mask : '0; cy = d[w-1]; end
                    else begin
                        res = '0;
                        for (int i = 0; i < w; i++) res[i] = (i + n < w) ? d[i+n] : d[w-1];
                        cy = d[n-1];
                    end
                end
                default: begin
                    if (n == 0) begin res = (d >> 1) | (64'(c) << (w - 1)); cy = d[0]; end
                    else begin
                        r   = n % w;
                        res = '0;
                        for (int i = 0; i < w; i++) res[i] = d[(i + r) % w];
                        cy  = (r == 0) ? d[w-1] : d[r-1];
                    end
                end
            endcase
        end
        return {cy, res};
    endfunction

    // ---------------- test ----------------
    initial begin
        logic [63:0] d;
        logic [64:0] m8, m64;
        int          pops;

        set_vec(0,  "lsl_reg1",   3'b001, 8'd1,   32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        set_vec(1,  "lsl_reg33",  3'b001, 8'd33,  32'h8000_0001, 1'b1, 32'h0000_0000, 1'b0);
        set_vec(2,  "lsr_imm0",   3'b010, 8'd0,   32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        set_vec(3,  "asr_imm0",   3'b100, 8'd0,   32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        set_vec(4,  "asr_reg4",   3'b101, 8'd4,   32'hF000_0010, 1'b1, 32'hFF00_0001, 1'b0);
        set_vec(5,  "ror_reg1",   3'b111, 8'd1,   32'h0000_0003, 1'b0, 32'h8000_0001, 1'b1);
        set_vec(6,  "ror_reg32",  3'b111, 8'd32,  32'h0000_0003, 1'b1, 32'h0000_0003, 1'b0);
        set_vec(7,  "rrx",        3'b110, 8'd0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1);
        set_vec(8,  "reg_pass",   3'b011, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1);
        set_vec(9,  "lsl_imm0",   3'b000, 8'd0,   32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1);
        set_vec(10, "lsl_reg32",  3'b001, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        set_vec(11, "lsr_reg32",  3'b011, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        set_vec(12, "lsr_reg33",  3'b011, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
        set_vec(13, "asr_reg40",  3'b101, 8'd40,  32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
        set_vec(14, "ror_reg36",  3'b111, 8'd36,  32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1);
        set_vec(15, "lsr_reg4",   3'b011, 8'd4,   32'h0000_001F, 1'b0, 32'h0000_0001, 1'b1);
        set_vec(16, "lsl_imm4",   3'b000, 8'd4,   32'hF000_000F, 1'b0, 32'h0000_00F0, 1'b1);
        set_vec(17, "ror_imm8",   3'b110, 8'd8,   32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0);
        set_vec(18, "asr_reg31",  3'b101, 8'd31,  32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0);
        set_vec(19, "lsl_reg255", 3'b001, 8'd255, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        SHIFT_OP = '0; Shift_Num = '0; Shift_Data = '0; Carry_flag = 1'b0;
        s_in_valid = 1'b0; s_c = 1'b0; s_op = '0;
        s8_num = '0; s64_num = '0; s8_data = '0; s64_data = '0;

        #2;
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.out", Shift_out, '0);
        check("reset.carry", Shift_carry_out, 1'b0);
        check("reset.in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: latency of exactly two edges, carry sampled at acceptance.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive_vec(i);
            @(negedge clk);
            check({vecs[i].name, ".in_ready"}, in_ready, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            Carry_flag = ~vecs[i].c;
            @(negedge clk);
            check({vecs[i].name, ".early"}, out_valid, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check_result(vecs[i].name, i);
        end

        // Bubble between two requests.
        @(posedge clk); #1; drive_vec(0);
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; drive_vec(4);
        @(negedge clk);
        check_result("bubble_a", 0);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        check("bubble.gap_valid", out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        check_result("bubble_b", 4);

        // Back-pressure: four back-to-back requests, output stalled three cycles.
        @(posedge clk); #1;
        pops = 0;
        fork
            begin : bp_drv
                int sel[4];
                int waited;
                sel = '{0, 3, 5, 14};
                for (int i = 0; i < 4; i++) begin
                    drive_vec(sel[i]);
                    waited = 0;
                    @(negedge clk);
                    while (!in_ready && waited < 20) begin
                        @(negedge clk);
                        waited++;
                    end
                    check("bp.in_ready_wait", in_ready, 1'b1);
                    if (in_ready) exp_q.push_back({vecs[sel[i]].exp_c, vecs[sel[i]].exp_out});
                    @(posedge clk); #1;
                    Carry_flag = ~Carry_flag;
                end
                in_valid = 1'b0;
            end
            begin : bp_stall
                int waited;
                waited = 0;
                @(negedge clk);
                while (!out_valid && waited < 20) begin
                    @(negedge clk);
                    waited++;
                end
                check("bp.first_valid", out_valid, 1'b1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp.stall_in_ready", in_ready, 1'b0);
                    check("bp.stall_valid", out_valid, 1'b1);
                    if (exp_q.size() > 0) begin
                        check("bp.stall_out", Shift_out, exp_q[0][W-1:0]);
                        check("bp.stall_carry", Shift_carry_out, exp_q[0][W]);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
            begin : bp_mon
                logic [W:0] e;
                for (int cyc = 0; cyc < 40 && pops < 4; cyc++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk_cnt++;
                            $display("FAIL bp.unexpected: got result 0x%0h, expected none", Shift_out);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("bp.out%0d", pops), Shift_out, e[W-1:0]);
                            check($sformatf("bp.carry%0d", pops), Shift_carry_out, e[W]);
                        end
                        pops++;
                    end
                end
            end
        join
        check("bp.result_count", pops, 4);
        check("bp.queue_empty", exp_q.size(), 0);

        // Reset with two requests in flight.
        @(posedge clk); #1; drive_vec(5);
        @(posedge clk); #1; drive_vec(15);
        @(posedge clk); #1; in_valid = 1'b0;
        check("rst_mid.pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.out_valid", out_valid, 1'b0);
        check("rst_mid.out", Shift_out, '0);
        check("rst_mid.carry", Shift_carry_out, 1'b0);
        check("rst_mid.in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid.no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1; drive_vec(6);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid.early", out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        check_result("rst_mid.first", 6);

        // WIDTH = 8 and 64 sweep against the reference model.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            d        = {$urandom, $urandom};
            s8_data  = d[7:0];
            s64_data = d;
            s_op     = 3'($urandom_range(0, 7));
            s_c      = 1'($urandom_range(0, 1));
            if (i % 8 == 0) begin
                s8_num = '0; s64_num = '0;
            end else if (i % 4 == 3) begin
                s8_num = NW'($urandom_range(0, 255)); s64_num = NW'($urandom_range(0, 255));
            end else begin
                s8_num = NW'($urandom_range(1, 17)); s64_num = NW'($urandom_range(1, 129));
            end
            s_in_valid = 1'b1;
            m8  = model(8,  64'(s8_data), int'(s8_num), s_op, s_c);
            m64 = model(64, s64_data, int'(s64_num), s_op, s_c);
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            s_c = ~s_c;
            @(posedge clk); @(negedge clk);
            check($sformatf("sweep8_%0d.valid", i), s8_out_valid, 1'b1);
            check($sformatf("sweep8_%0d.out op%0d n%0d", i, s_op, s8_num), 64'(s8_out), m8[63:0]);
            check($sformatf("sweep8_%0d.carry", i), s8_carry, m8[64]);
            check($sformatf("sweep64_%0d.valid", i), s64_out_valid, 1'b1);
            check($sformatf("sweep64_%0d.out op%0d n%0d", i, s_op, s64_num), s64_out, m64[63:0]);
            check($sformatf("sweep64_%0d.carry", i), s64_carry, m64[64]);
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
